// File: rtl/sfq_gate_pkg.sv
// Shared types and helpers for the clocked-SFQ threshold gate model.
package sfq_gate_pkg;

    localparam int MAX_N_IN = 16;
    // Width able to hold a count of 0..MAX_N_IN.
    localparam int CNT_W    = 5;

    typedef enum logic [1:0] {
        GATE_AND = 2'd0,
        GATE_OR  = 2'd1,
        GATE_MAJ = 2'd2,
        GATE_THR = 2'd3
    } gate_mode_e;

    // Number of set bits in a vector zero-extended to MAX_N_IN.
    function automatic logic [CNT_W-1:0] popcount(input logic [MAX_N_IN-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_N_IN; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/sfq_tgl_pulse_det.sv
// Toggle-to-pulse converter: every level change on a toggle-encoded line
// becomes a single-cycle pulse, visible in the cycle the new level is present.
module sfq_tgl_pulse_det #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tgl,
    output logic [WIDTH-1:0] pulse
);

    logic [WIDTH-1:0] tgl_q;

    // Remember the previous level of every line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgl_q <= '0;
        end else begin
            tgl_q <= tgl;
        end
    end

    assign pulse = tgl ^ tgl_q;

endmodule

// File: rtl/sfq_threshold_gate.sv
// Clocked SFQ gate model over N_IN toggle-encoded inputs: AND / OR / MAJORITY /
// THRESHOLD on the stored-flux (armed) state, evaluated on each SFQ clock pulse.
// A second pulse on an already armed input within one period is dropped and
// flagged. Optional macro SFQ_GATE_ERR_CNT_EN adds a saturating duplicate counter.
module sfq_threshold_gate
    import sfq_gate_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int MODE   = 0,
    parameter int THRESH = 1,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   din_tgl,
    input  logic              sclk_tgl,
    output logic              dout_tgl,
    output logic [N_IN-1:0]   armed,
`ifdef SFQ_GATE_ERR_CNT_EN
    output logic [ERR_W-1:0]  err_cnt,
`endif
    output logic              err
);

    // Reject configurations the gate cannot represent.
    generate
        if (N_IN < 2 || N_IN > MAX_N_IN) begin : g_bad_n_in
            $error("sfq_threshold_gate: N_IN=%0d outside 2..%0d", N_IN, MAX_N_IN);
        end
        if (MODE < 0 || MODE > 3) begin : g_bad_mode
            $error("sfq_threshold_gate: MODE=%0d outside 0..3", MODE);
        end
        if (MODE == 3 && (THRESH < 1 || THRESH > N_IN)) begin : g_bad_thresh
            $error("sfq_threshold_gate: THRESH=%0d outside 1..N_IN", THRESH);
        end
        if (ERR_W < 1) begin : g_bad_err_w
            $error("sfq_threshold_gate: ERR_W must be at least 1");
        end
    endgenerate

    localparam gate_mode_e       GATE_MODE = gate_mode_e'(2'(MODE));
    localparam logic [CNT_W-1:0] ALL_LIM   = CNT_W'(N_IN);
    localparam logic [CNT_W-1:0] MAJ_LIM   = CNT_W'(N_IN / 2);
    localparam logic [CNT_W-1:0] THR_LIM   = CNT_W'(THRESH);

    logic [N_IN-1:0]  p;
    logic             ps;
    logic [N_IN-1:0]  armed_reg;
    logic [N_IN-1:0]  armed_next;
    logic [N_IN-1:0]  dup;
    logic [CNT_W-1:0] armed_cnt;
    logic             fire;
    logic             dout_reg;
    logic             err_reg;

    sfq_tgl_pulse_det #(.WIDTH(N_IN)) u_din_det (
        .clk   (clk),
        .rst_n (rst_n),
        .tgl   (din_tgl),
        .pulse (p)
    );

    sfq_tgl_pulse_det #(.WIDTH(1)) u_sclk_det (
        .clk   (clk),
        .rst_n (rst_n),
        .tgl   (sclk_tgl),
        .pulse (ps)
    );

    // Per input: a clock pulse clears stored flux first, so a coincident data
    // pulse arms the next period; otherwise a pulse on an armed input is a duplicate.
    genvar gi;
    generate
        for (gi = 0; gi < N_IN; gi++) begin : g_in
            assign armed_next[gi] = ps ? p[gi] : (armed_reg[gi] | p[gi]);
            assign dup[gi]        = p[gi] & armed_reg[gi] & ~ps;
        end
    endgenerate

    // Fire decision on the armed state held before this clock pulse.
    always_comb begin
        fire      = 1'b0;
        armed_cnt = popcount(MAX_N_IN'(armed_reg));
        unique case (GATE_MODE)
            GATE_AND: fire = (armed_cnt == ALL_LIM);
            GATE_OR:  fire = (armed_cnt != '0);
            GATE_MAJ: fire = (armed_cnt > MAJ_LIM);
            GATE_THR: fire = (armed_cnt >= THR_LIM);
            default:  fire = 1'b0;
        endcase
        // An empty gate never fires, whatever the mode.
        if (!ps || armed_cnt == '0) begin
            fire = 1'b0;
        end
    end

    // Stored flux, output toggle flop and sticky duplicate flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_reg <= '0;
            dout_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            armed_reg <= armed_next;
            if (fire) begin
                dout_reg <= ~dout_reg;
            end
            if (|dup) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign armed    = armed_reg;
    assign dout_tgl = dout_reg;
    assign err      = err_reg;

`ifdef SFQ_GATE_ERR_CNT_EN
    localparam int               SUM_W   = ERR_W + CNT_W;
    localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};

    logic [ERR_W-1:0] err_cnt_reg;
    logic [ERR_W-1:0] err_cnt_next;
    logic [SUM_W-1:0] err_sum;

    // Several inputs may duplicate in the same cycle; add them all, then saturate.
    always_comb begin
        err_sum      = SUM_W'(err_cnt_reg) + SUM_W'(popcount(MAX_N_IN'(dup)));
        err_cnt_next = err_sum[ERR_W-1:0];
        if (err_sum > SUM_W'(CNT_MAX)) begin
            err_cnt_next = CNT_MAX;
        end
    end

    // Duplicate-pulse counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_reg <= '0;
        end else begin
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign err_cnt = err_cnt_reg;
`endif

endmodule
